// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart transmit arbiter: arbiter FSM states,
// byte width and the pointer-width helper used by the top and the picker.
package omicron_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Pointer width for n requesters, never narrower than one bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart-side byte channels of the transmit arbiter.
// The master modport is the environment (requesters plus uart), the slave
// modport is the arbiter itself.
interface uart_tx_arbiter_if
    import omicron_pkg::*;
#(
    parameter int NREQ = 2
);

    logic [BYTE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_data_valid;
    logic                   tx_data_ready;
    logic [NREQ-1:0]        grant;
    logic                   timeout_err;

    modport master (
        output req_data, req_valid, req_last, tx_data_ready,
        input  req_ready, tx_data, tx_data_valid, grant, timeout_err
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_data_ready,
        output req_ready, tx_data, tx_data_valid, grant, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// after i_last_grant, wrapping from NREQ-1 back to 0 by comparison so that
// non-power-of-two requester counts wrap correctly.
module rr_pick
    import omicron_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int PTR_W = ptr_width(NREQ)
)(
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_last_grant,
    output logic [NREQ-1:0]  o_onehot,
    output logic [PTR_W-1:0] o_index
);

    logic [PTR_W-1:0] w_cand;
    logic             w_found;

    // Walk the candidates starting just after the previous owner and keep the first hit
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        w_cand   = i_last_grant;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_cand == PTR_W'(NREQ - 1)) begin
                w_cand = '0;
            end else begin
                w_cand = w_cand + 1'b1;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_index = w_cand;
            end
        end
        if (w_found) begin
            o_onehot[o_index] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the uart transmit byte channel
// between NREQ requesters, with a one-entry output register toward the uart.
// Optional stall watchdog: define UART_TX_ARB_TIMEOUT_EN to revoke a grant
// after TIMEOUT_CYCLES cycles without an accepted byte.
module uart_tx_arbiter
    import omicron_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 48000
)(
    input logic              i_clk_48,
    input logic              i_rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int PTR_W = ptr_width(NREQ);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   w_next_grant;
    logic [PTR_W-1:0]  r_last_grant;
    logic [PTR_W-1:0]  w_next_last_grant;
    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  w_next_owner;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic [NREQ-1:0]   w_pick_onehot;
    logic [PTR_W-1:0]  w_pick_index;
    logic [NREQ-1:0]   w_req_ready;
    logic [NREQ-1:0]   w_xfer;
    logic              w_accept;
    logic              w_accept_last;
    logic              w_timeout_hit;
    logic [BYTE_W-1:0] w_owner_data;

    // The owner may push whenever the output register is empty or draining this cycle
    assign w_req_ready   = r_grant & {NREQ{~r_tx_valid | bus.tx_data_ready}};
    assign w_xfer        = bus.req_valid & w_req_ready;
    assign w_accept      = |w_xfer;
    assign w_accept_last = |(w_xfer & bus.req_last);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_onehot     (w_pick_onehot),
        .o_index      (w_pick_index)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_stall_cnt;

    assign w_timeout_hit = (r_state == ARB_GRANT) && !w_accept &&
                           (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count grant cycles without progress; a fresh grant or any accepted byte restarts it
    always_ff @(posedge i_clk_48) begin
        if (i_rst || (r_state != ARB_GRANT) || w_accept || w_timeout_hit) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Select the current owner's byte lane
    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == PTR_W'(i)) begin
                w_owner_data = bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the owner until its last byte or a revoke
    always_comb begin
        w_next_state      = r_state;
        w_next_grant      = r_grant;
        w_next_last_grant = r_last_grant;
        w_next_owner      = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (|bus.req_valid) begin
                    w_next_state = ARB_GRANT;
                    w_next_grant = w_pick_onehot;
                    w_next_owner = w_pick_index;
                end
            end
            ARB_GRANT: begin
                if (w_accept_last || w_timeout_hit) begin
                    w_next_state      = ARB_IDLE;
                    w_next_grant      = '0;
                    w_next_last_grant = r_owner;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    // Arbiter state registers; pointer starts at the top so requester 0 wins first
    always_ff @(posedge i_clk_48) begin
        if (i_rst) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_grant <= PTR_W'(NREQ - 1);
            r_owner      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_last_grant;
            r_owner      <= w_next_owner;
        end
    end

    // One-entry output register: load on accept, empty when the uart takes the byte
    always_ff @(posedge i_clk_48) begin
        if (i_rst) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_accept) begin
            r_tx_data  <= w_owner_data;
            r_tx_valid <= 1'b1;
        end else if (r_tx_valid && bus.tx_data_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.tx_data       = r_tx_data;
    assign bus.tx_data_valid = r_tx_valid;
    assign bus.grant         = r_grant;
    assign bus.timeout_err   = w_timeout_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NREQ=2, TIMEOUT_CYCLES=16) plus
// standalone checks of the rr_pick round-robin picker at NREQ=4 and NREQ=3.
// Timeout scenario expectations follow UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(2)) bus();

    uart_tx_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(16)) dut (
        .i_clk_48 (clk),
        .i_rst    (rst),
        .bus      (bus)
    );

    logic [3:0] pickReq4;
    logic [1:0] pickLast4;
    logic [3:0] pickHot4;
    logic [1:0] pickIdx4;
    logic [2:0] pickReq3;
    logic [1:0] pickLast3;
    logic [2:0] pickHot3;
    logic [1:0] pickIdx3;

    rr_pick #(.NREQ(4)) pick4 (
        .i_req        (pickReq4),
        .i_last_grant (pickLast4),
        .o_onehot     (pickHot4),
        .o_index      (pickIdx4)
    );

    rr_pick #(.NREQ(3)) pick3 (
        .i_req        (pickReq3),
        .i_last_grant (pickLast3),
        .o_onehot     (pickHot3),
        .o_index      (pickIdx3)
    );

    int         checkCount = 0;
    int         passCount  = 0;
    int         extraCount = 0;
    int         cycleNo    = 0;
    int         baseCycle  = 0;
    logic [7:0] sbQ[$];
    logic [8:0] stimQ0[$];
    logic [8:0] stimQ1[$];
    logic [1:0] hs = 2'b00;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Queue one byte for requester r; bit 8 of the entry carries the last flag
    task automatic applyStimulus(input int r, input logic [7:0] data, input logic last);
        if (r == 0) stimQ0.push_back({last, data});
        else        stimQ1.push_back({last, data});
    endtask

    task automatic expectByte(input logic [7:0] data);
        sbQ.push_back(data);
    endtask

    // Marks cycle 0 of a scenario just after a rising edge
    task automatic startTest();
        @(posedge clk);
        #1;
        baseCycle = cycleNo;
    endtask

    // Moves to the falling edge inside cycle k of the current scenario
    task automatic atCycle(input int k);
        @(negedge clk);
        while (cycleNo < baseCycle + k) @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        stimQ0.delete();
        stimQ1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then confirm nothing is left or extra
    task automatic drainCheck(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (sbQ.size() > 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput({tag, "_left"}, sbQ.size(), 0);
        checkOutput({tag, "_extra"}, extraCount, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_txData"},  bus.tx_data, 8'h00);
        checkOutput({tag, "_txValid"}, bus.tx_data_valid, 1'b0);
        checkOutput({tag, "_grant"},   bus.grant, 2'b00);
        checkOutput({tag, "_ready"},   bus.req_ready, 2'b00);
        checkOutput({tag, "_tmo"},     bus.timeout_err, 1'b0);
    endtask

    function automatic logic [7:0] rrModel(input logic [7:0] req, input int last, input int n, output int idx);
        int c;
        idx = -1;
        for (int k = 1; k <= n; k++) begin
            c = (last + k) % n;
            if (req[c]) begin
                idx = c;
                return 8'(1 << c);
            end
        end
        return 8'h00;
    endfunction

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Monitor: capture requester handshakes and score every uart-side transfer
    always @(negedge clk) begin
        hs = bus.req_valid & bus.req_ready;
        if (bus.tx_data_valid === 1'b1 && bus.tx_data_ready === 1'b1) begin
            if (sbQ.size() == 0) extraCount++;
            else checkOutput("sbData", bus.tx_data, sbQ.pop_front());
        end
    end

    // Requester drivers: present the head of each queue, advance after a handshake
    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (hs[0] && stimQ0.size() > 0) void'(stimQ0.pop_front());
            if (hs[1] && stimQ1.size() > 0) void'(stimQ1.pop_front());
            bus.req_valid[0] = (stimQ0.size() > 0);
            bus.req_data[7:0] = (stimQ0.size() > 0) ? stimQ0[0][7:0] : 8'h00;
            bus.req_last[0]  = (stimQ0.size() > 0) ? stimQ0[0][8] : 1'b0;
            bus.req_valid[1] = (stimQ1.size() > 0);
            bus.req_data[15:8] = (stimQ1.size() > 0) ? stimQ1[0][7:0] : 8'h00;
            bus.req_last[1]  = (stimQ1.size() > 0) ? stimQ1[0][8] : 1'b0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp4Idx;
        int exp3Idx;
        int bad;
        logic [7:0] exp4;
        logic [7:0] exp3;

        bus.tx_data_ready = 1'b1;
        pickReq4 = '0; pickLast4 = '0; pickReq3 = '0; pickLast3 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("reset");

        // Single requester, three-byte packet at full rate
        startTest();
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b1);
        expectByte(8'h41); expectByte(8'h42); expectByte(8'h43);
        atCycle(1);
        checkOutput("t1GrantC1", bus.grant, 2'b01);
        checkOutput("t1ReadyC1", bus.req_ready, 2'b01);
        atCycle(2);
        checkOutput("t1ValidC2", bus.tx_data_valid, 1'b1);
        checkOutput("t1DataC2", bus.tx_data, 8'h41);
        atCycle(3);
        checkOutput("t1DataC3", bus.tx_data, 8'h42);
        atCycle(4);
        checkOutput("t1DataC4", bus.tx_data, 8'h43);
        atCycle(5);
        checkOutput("t1GrantC5", bus.grant, 2'b00);
        checkOutput("t1ValidC5", bus.tx_data_valid, 1'b0);
        drainCheck("t1", 30);

        // Two requesters from reset: whole packets, requester 0 first
        doReset();
        startTest();
        applyStimulus(0, 8'h10, 1'b0); applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(1, 8'h20, 1'b0); applyStimulus(1, 8'h21, 1'b1);
        expectByte(8'h10); expectByte(8'h11); expectByte(8'h20); expectByte(8'h21);
        atCycle(1);
        checkOutput("t2GrantC1", bus.grant, 2'b01);
        atCycle(3);
        checkOutput("t2GrantC3", bus.grant, 2'b00);
        atCycle(4);
        checkOutput("t2GrantC4", bus.grant, 2'b10);
        drainCheck("t2", 30);

        // Continuous single-byte packets strictly alternate
        doReset();
        startTest();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'hA0, 1'b1);
            applyStimulus(1, 8'hB0, 1'b1);
            expectByte(8'hA0);
            expectByte(8'hB0);
        end
        drainCheck("t3", 60);

        // Uart stall with a byte buffered
        doReset();
        startTest();
        bus.tx_data_ready = 1'b0;
        applyStimulus(0, 8'h55, 1'b0);
        applyStimulus(0, 8'h56, 1'b1);
        expectByte(8'h55); expectByte(8'h56);
        atCycle(2);
        checkOutput("t4DataC2", bus.tx_data, 8'h55);
        checkOutput("t4ReadyC2", bus.req_ready, 2'b00);
        bad = 0;
        for (int c = 3; c <= 11; c++) begin
            atCycle(c);
            if (bus.tx_data !== 8'h55 || bus.tx_data_valid !== 1'b1 || bus.req_ready !== 2'b00) bad++;
        end
        checkOutput("t4Stable", bad, 0);
        @(posedge clk);
        #1;
        bus.tx_data_ready = 1'b1;
        atCycle(12);
        checkOutput("t4DataC12", bus.tx_data, 8'h55);
        atCycle(13);
        checkOutput("t4DataC13", bus.tx_data, 8'h56);
        drainCheck("t4", 30);

        // Reset after the second byte of a four-byte packet
        doReset();
        startTest();
        applyStimulus(0, 8'h31, 1'b0); applyStimulus(0, 8'h32, 1'b0);
        applyStimulus(0, 8'h33, 1'b0); applyStimulus(0, 8'h34, 1'b1);
        expectByte(8'h31); expectByte(8'h32);
        atCycle(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stimQ0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("t5Reset");
        drainCheck("t5a", 10);
        startTest();
        applyStimulus(0, 8'h61, 1'b0); applyStimulus(0, 8'h62, 1'b1);
        expectByte(8'h61); expectByte(8'h62);
        atCycle(1);
        checkOutput("t5GrantC1", bus.grant, 2'b01);
        drainCheck("t5b", 30);

        // Owner stalls mid-packet while requester 1 waits
        doReset();
        startTest();
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(1, 8'h02, 1'b1);
        expectByte(8'h01);
`ifdef UART_TX_ARB_TIMEOUT_EN
        expectByte(8'h02);
        atCycle(16);
        checkOutput("t6TmoC16", bus.timeout_err, 1'b0);
        atCycle(17);
        checkOutput("t6TmoC17", bus.timeout_err, 1'b1);
        checkOutput("t6GrantC17", bus.grant, 2'b01);
        atCycle(18);
        checkOutput("t6TmoC18", bus.timeout_err, 1'b0);
        checkOutput("t6GrantC18", bus.grant, 2'b00);
        atCycle(19);
        checkOutput("t6GrantC19", bus.grant, 2'b10);
        drainCheck("t6", 30);
`else
        bad = 0;
        for (int c = 1; c <= 60; c++) begin
            atCycle(c);
            if (bus.grant !== 2'b01 || bus.timeout_err !== 1'b0) bad++;
        end
        checkOutput("t6HeldGrant", bad, 0);
        checkOutput("t6GrantEnd", bus.grant, 2'b01);
        drainCheck("t6", 10);
`endif
        doReset();

        // Standalone picker: directed wrap cases, then random patterns
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin
                pickReq4 = 4'b1111; pickLast4 = 2'd3;
                pickReq3 = 3'b001;  pickLast3 = 2'd2;
            end else if (i == 1) begin
                pickReq4 = 4'b0101; pickLast4 = 2'd0;
                pickReq3 = 3'b100;  pickLast3 = 2'd2;
            end else begin
                pickReq4  = 4'($urandom_range(0, 15));
                pickLast4 = 2'($urandom_range(0, 3));
                pickReq3  = 3'($urandom_range(0, 7));
                pickLast3 = 2'($urandom_range(0, 2));
            end
            #1;
            exp4 = rrModel({4'b0, pickReq4}, int'(pickLast4), 4, exp4Idx);
            exp3 = rrModel({5'b0, pickReq3}, int'(pickLast3), 3, exp3Idx);
            checkOutput("pick4Hot", pickHot4, exp4[3:0]);
            checkOutput("pick3Hot", pickHot3, exp3[2:0]);
            if (exp4Idx >= 0) checkOutput("pick4Idx", pickIdx4, exp4Idx);
            if (exp3Idx >= 0) checkOutput("pick3Idx", pickIdx3, exp3Idx);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart transmit byte channel (tx_data / tx_data_valid / tx_data_ready) between NREQ requesters, e.g. the echo path and a status/debug reporter.
- Arbitrates per packet: a requester, once granted, keeps the channel until it transfers a byte marked last.
- Selection among waiting requesters is round-robin.
- Sits in the clk_48 domain, between the requesters and uart0's tx_data port.

Parameters:
- NREQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 48000, stall limit in clk_48 cycles before a grant is revoked (used only with the optional feature; 48000 = 1 ms).

Ports:
- clk_48  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- req_data  input  8*NREQ  byte from requester i at bits [8i+7:8i].
- req_valid  input  NREQ  requester i has a byte.
- req_last  input  NREQ  the byte from requester i ends its packet; qualified by req_valid.
- req_ready  output  NREQ  the byte from requester i is accepted this cycle.
- tx_data  output  8  byte to uart.
- tx_data_valid  output  1  tx_data holds a byte.
- tx_data_ready  input  1  uart takes tx_data this cycle.
- grant  output  NREQ  one-hot current owner; all zero when idle.
- timeout_err  output  1  one-cycle pulse when a grant is revoked.

Behaviour:
- Reset values:
  - tx_data = 0, tx_data_valid = 0, grant = 0, req_ready = 0, timeout_err = 0.
  - State = IDLE.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 wins first after reset.
- Transfer definitions:
  - Requester side: a byte moves on any cycle where req_valid[i] and req_ready[i] are both high.
  - Uart side: a byte moves on any cycle where tx_data_valid and tx_data_ready are both high.
- One-entry output register:
  - req_ready[i] = grant[i] and (not tx_data_valid or tx_data_ready).
  - req_ready is combinational from registered state and tx_data_ready.
  - On an accept: tx_data <= req_data[g], tx_data_valid <= 1.
  - Otherwise, on a uart transfer: tx_data_valid <= 0.
  - Back-to-back bytes run at full rate when tx_data_ready is high.
- FSM states: IDLE, GRANT.
  - IDLE: if any req_valid is set, pick the first set bit searching from last_grant+1 with wrap-around. Register grant one-hot and go to GRANT. Nothing is accepted in IDLE.
  - GRANT: accept bytes from the owner. On an accepted byte with req_last set: grant <= 0, last_grant <= owner index, go to IDLE.
- Latency and throughput:
  - req_valid rises at cycle 0 → grant at cycle 1 → req_ready at cycle 1 (buffer empty) → tx_data_valid at cycle 2.
  - There is one idle arbitration cycle between packets; the output buffer can still drain during it.
- Boundary rules:
  - Owner drops req_valid mid-packet: grant is held (packet lock); no other requester is served.
  - Single-byte packet (valid and last together) is legal.
  - req_last without req_valid is ignored.
  - Requests from non-owners are ignored while in GRANT.
  - tx_data_ready while tx_data_valid = 0 has no effect.
  - tx_data and tx_data_valid stay stable while tx_data_valid = 1 and tx_data_ready = 0.
  - NREQ = 1: the pointer is trivial, but the IDLE→GRANT cycle is still present.
- Reset mid-packet: the next cycle shows all reset values; a buffered byte is discarded; the requester must restart its packet.
- Width rule: the pointer is $clog2(NREQ) bits wide, minimum 1; wrap-around is by compare to NREQ-1, not by power-of-two overflow.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every accepted byte and on entry to GRANT.
  - It increments every cycle in GRANT without an accept, including while the uart stalls.
  - When it reaches TIMEOUT_CYCLES-1: grant <= 0, last_grant <= owner index, go to IDLE, timeout_err = 1 for one cycle.
  - A byte already in the output register is still delivered.
- Undefined: no counter is built, timeout_err is tied to 0, and a grant is held indefinitely.

Decomposition:
- Shared package (omicron_pkg):
  - FSM state encodings ARB_IDLE and ARB_GRANT.
  - Byte width constant BYTE_W = 8.
- One sub-module, rr_pick: a combinational round-robin picker with inputs req[NREQ] and last_grant and outputs onehot and index. Tested standalone.

Test Plan:
- Req0 sends packet 0x41, 0x42, 0x43 (last on 0x43), tx_data_ready always 1 → uart sees 0x41, 0x42, 0x43 on cycles 2, 3, 4; grant = 0 on cycle 5.
- Req0 and req1 both valid from reset with 2-byte packets 0x10, 0x11 and 0x20, 0x21 → order is 0x10, 0x11, 0x20, 0x21; grant goes 01 → 00 → 10.
- Req0 and req1 continuously request 1-byte packets 0xA0 and 0xB0 → uart stream strictly alternates 0xA0, 0xB0, 0xA0, …
- tx_data_ready held 0 for 10 cycles with byte 0x55 buffered → tx_data = 0x55 stable; req_ready = 0; next byte 0x56 follows with no loss or duplication.
- rst asserted for one cycle after the 2nd byte of a 4-byte packet → all outputs at reset values the next cycle; a fresh packet then transfers correctly from req0.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: req0 sends 0x01 without last, then drops valid; req1 is waiting → timeout_err pulses exactly 16 cycles after the accept of 0x01, then req1 is granted; without the macro, req1 is never granted.
